// File: rtl/tl_ram_responder_if.sv
// TileLink-UH channel A/D bundle between a host (master) and a device endpoint (slave).
// Valid/ready: a beat transfers on a rising clock edge where valid && ready are both high.
// A source holding valid keeps every payload field stable until that edge; ready never depends on valid.
interface tl_ram_responder_if #(
  parameter int DataWidth   = 64,
  parameter int AddrWidth   = 56,
  parameter int SourceWidth = 4,
  parameter int SinkWidth   = 1
);
  logic                     a_valid;
  logic                     a_ready;
  logic [2:0]               a_opcode;
  logic [2:0]               a_param;
  logic [2:0]               a_size;
  logic [SourceWidth-1:0]   a_source;
  logic [AddrWidth-1:0]     a_address;
  logic [DataWidth/8-1:0]   a_mask;
  logic                     a_corrupt;
  logic [DataWidth-1:0]     a_data;

  logic                     d_valid;
  logic                     d_ready;
  logic [2:0]               d_opcode;
  logic [1:0]               d_param;
  logic [2:0]               d_size;
  logic [SourceWidth-1:0]   d_source;
  logic [SinkWidth-1:0]     d_sink;
  logic                     d_denied;
  logic                     d_corrupt;
  logic [DataWidth-1:0]     d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt, a_data,
    output d_ready,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt, a_data,
    input  d_ready,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data
  );
endinterface

// File: rtl/tl_ram_responder.sv
// TileLink-UH device endpoint over a flop-based word memory: serves Get/Put/Intent bursts,
// denies Arithmetic/Logical requests with corrupt AccessAckData.
module tl_ram_responder #(
  parameter int DataWidth   = 64,
  parameter int AddrWidth   = 56,
  parameter int SourceWidth = 4,
  parameter int SinkWidth   = 1,
  parameter int MaxSize     = 6,
  parameter int DepthWords  = 512,
  parameter int SinkId      = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  tl_ram_responder_if.slave   host,
  output logic [1:0]          dbg_state_o
);
  localparam int LgBytes = $clog2(DataWidth / 8);
  localparam int IdxW    = $clog2(DepthWords);
  localparam int BeatW   = 8;
  localparam int Lanes   = DataWidth / 8;
  localparam logic [2:0] LgBytesL = 3'(LgBytes);
  localparam logic [2:0] MaxSizeL = 3'(MaxSize);

  localparam logic [2:0] OpPutFull    = 3'd0;
  localparam logic [2:0] OpPutPartial = 3'd1;
  localparam logic [2:0] OpGet        = 3'd4;
  localparam logic [2:0] OpIntent     = 3'd5;

  localparam logic [2:0] DAccessAck     = 3'd0;
  localparam logic [2:0] DAccessAckData = 3'd1;
  localparam logic [2:0] DHintAck       = 3'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    ACK   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [2:0]             size_q, size_d;
  logic [SourceWidth-1:0] source_q, source_d;
  logic [IdxW-1:0]        base_q, base_d;
  logic [BeatW-1:0]       beat_q, beat_d;

  logic [DataWidth-1:0]   mem [DepthWords];

  logic                   a_ready_c, d_valid_c, a_fire, d_fire;
  logic [IdxW-1:0]        a_idx, cur_idx, wr_idx;
  logic                   last_beat, atomic_q, wr_en;
  logic [2:0]             d_opcode_c;
  logic                   d_denied_c, d_corrupt_c;
  logic [DataWidth-1:0]   d_data_c;

  function automatic logic [BeatW-1:0] last_beat_of(input logic [2:0] size);
    if (size <= LgBytesL) return '0;
    return (BeatW'(1) << (size - LgBytesL)) - BeatW'(1);
  endfunction

  function automatic logic is_put(input logic [2:0] op);
    return (op == OpPutFull) || (op == OpPutPartial);
  endfunction

  assign a_ready_c = !rst_i && ((state_q == IDLE) || (state_q == WRITE));
  assign d_valid_c = (state_q == READ) || (state_q == ACK);
  assign a_fire    = host.a_valid && a_ready_c;
  assign d_fire    = d_valid_c && host.d_ready;
  assign a_idx     = host.a_address[LgBytes +: IdxW];
  assign cur_idx   = base_q + IdxW'(beat_q);
  assign last_beat = (beat_q == last_beat_of(size_q));
  assign atomic_q  = !is_put(op_q) && (op_q != OpGet) && (op_q != OpIntent);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    size_d      = size_q;
    source_d    = source_q;
    base_d      = base_q;
    beat_d      = beat_q;
    wr_en       = 1'b0;
    wr_idx      = cur_idx;
    d_opcode_c  = DAccessAck;
    d_denied_c  = 1'b0;
    d_corrupt_c = 1'b0;
    d_data_c    = '0;
    case (state_q)
      IDLE: begin
        wr_idx = a_idx;
        if (a_fire) begin
          op_d     = host.a_opcode;
          size_d   = host.a_size;
          source_d = host.a_source;
          base_d   = a_idx;
          beat_d   = '0;
          if (host.a_opcode == OpGet) begin
            state_d = READ;
          end else if (host.a_opcode == OpIntent) begin
            state_d = ACK;
          end else begin
            wr_en = is_put(host.a_opcode) && !host.a_corrupt;
            if (last_beat_of(host.a_size) == '0) begin
              state_d = ACK;
            end else begin
              // Beat 0 is consumed by this handshake, so WRITE resumes at beat 1.
              beat_d  = BeatW'(1);
              state_d = WRITE;
            end
          end
        end
      end
      WRITE: begin
        if (a_fire) begin
          wr_en = is_put(op_q) && !host.a_corrupt;
          if (last_beat) begin
            beat_d  = '0;
            state_d = ACK;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      READ: begin
        d_opcode_c = DAccessAckData;
        d_data_c   = mem[cur_idx];
        if (d_fire) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      ACK: begin
        if (atomic_q) begin
          // Denied atomics still return one data beat per requested beat.
          d_opcode_c  = DAccessAckData;
          d_denied_c  = 1'b1;
          d_corrupt_c = 1'b1;
          if (d_fire) begin
            if (last_beat) begin
              beat_d  = '0;
              state_d = IDLE;
            end else begin
              beat_d = beat_q + BeatW'(1);
            end
          end
        end else begin
          d_opcode_c = (op_q == OpIntent) ? DHintAck : DAccessAck;
          if (d_fire) begin
            beat_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      size_q   <= '0;
      source_q <= '0;
      base_q   <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      size_q   <= size_d;
      source_q <= source_d;
      base_q   <= base_d;
      beat_q   <= beat_d;
    end
  end

  // Memory has no reset: contents survive rst_i, including a partly written burst.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < Lanes; b++) begin
        if (host.a_mask[b]) mem[wr_idx][b*8 +: 8] <= host.a_data[b*8 +: 8];
      end
    end
  end

  assign host.a_ready   = a_ready_c;
  assign host.d_valid   = d_valid_c;
  assign host.d_opcode  = d_opcode_c;
  assign host.d_param   = 2'b00;
  assign host.d_size    = size_q;
  assign host.d_source  = source_q;
  assign host.d_sink    = SinkWidth'(SinkId);
  assign host.d_denied  = d_denied_c;
  assign host.d_corrupt = d_corrupt_c;
  assign host.d_data    = d_data_c;
  assign dbg_state_o    = state_q;

  logic unused_inputs;
  assign unused_inputs = ^{host.a_param, host.a_address};

  a_size_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    a_fire |-> (host.a_size <= MaxSizeL));
endmodule

// File: tb/tb_tl_ram_responder.sv
// Directed and randomized checks of tl_ram_responder against a word-array reference model.
module tb_tl_ram_responder;
  localparam int DW = 64;
  localparam int AW = 56;
  localparam int SW = 4;
  localparam int KW = 1;
  localparam int DEPTH = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  tl_ram_responder_if #(.DataWidth(DW), .AddrWidth(AW), .SourceWidth(SW), .SinkWidth(KW)) host();

  tl_ram_responder #(
    .DataWidth(DW), .AddrWidth(AW), .SourceWidth(SW), .SinkWidth(KW),
    .MaxSize(6), .DepthWords(DEPTH), .SinkId(0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .host(host),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;

  logic [63:0] ref_mem [DEPTH];
  logic [63:0] beat_data [16];
  logic [7:0]  beat_mask [16];
  logic        beat_corrupt [16];
  logic [63:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int n_beats(input int sz);
    return (sz <= 3) ? 1 : (1 << (sz - 3));
  endfunction

  function automatic int word_of(input logic [55:0] addr, input int k);
    logic [55:0] w;
    w = (addr >> 3) + 56'(k);
    return int'(w % 56'(DEPTH));
  endfunction

  task automatic send_beat(input logic [2:0] op, input logic [2:0] sz, input logic [55:0] addr,
                           input logic [3:0] src, input logic [63:0] data, input logic [7:0] mask,
                           input logic cor);
    bit done = 0;
    host.a_valid   = 1'b1;
    host.a_opcode  = op;
    host.a_param   = 3'($urandom_range(0, 7));
    host.a_size    = sz;
    host.a_source  = src;
    host.a_address = addr;
    host.a_mask    = mask;
    host.a_corrupt = cor;
    host.a_data    = data;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (host.a_ready) begin
        done = 1;
        @(posedge clk);
      end
      @(negedge clk);
    end
    host.a_valid = 1'b0;
    if (!done) check("a_ready_timeout", host.a_ready, 64'd1);
  endtask

  task automatic recv_beat(input bit rand_ready, output logic [63:0] data, output logic [2:0] opc,
                           output logic den, output logic cor, output logic [2:0] sz,
                           output logic [3:0] src);
    bit          done = 0;
    bit          have_prev = 0;
    logic [63:0] prev = '0;
    data = '0; opc = '0; den = 1'b0; cor = 1'b0; sz = '0; src = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      host.d_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (host.d_valid) begin
        if (have_prev) check("d_hold_while_stalled", host.d_data, prev);
        if (host.d_ready) begin
          data = host.d_data;  opc = host.d_opcode; den = host.d_denied;
          cor  = host.d_corrupt; sz = host.d_size;  src = host.d_source;
          done = 1;
          @(posedge clk);
        end else begin
          have_prev = 1;
          prev      = host.d_data;
        end
      end
      @(negedge clk);
    end
    host.d_ready = 1'b0;
    if (!done) check("d_valid_timeout", host.d_valid, 64'd1);
  endtask

  // Put/Arithmetic/Logical/Intent transaction using beat_data/beat_mask/beat_corrupt.
  task automatic put_txn(input logic [2:0] op, input int sz, input logic [55:0] addr, input logic [3:0] src);
    int          nb, na, nr;
    bit          atomic;
    logic [63:0] d;
    logic [2:0]  opc, rsz;
    logic        den, cor;
    logic [3:0]  rsrc;
    nb     = n_beats(sz);
    atomic = (op == 3'd2) || (op == 3'd3);
    na     = (op == 3'd5) ? 1 : nb;
    for (int k = 0; k < na; k++)
      send_beat(op, 3'(sz), addr, src, beat_data[k], beat_mask[k], beat_corrupt[k]);
    #1;
    check("ack_valid_latency", host.d_valid, 64'd1);
    check("ack_a_ready_low", host.a_ready, 64'd0);
    if (op == 3'd0 || op == 3'd1) begin
      for (int k = 0; k < nb; k++) begin
        if (!beat_corrupt[k]) begin
          for (int b = 0; b < 8; b++)
            if (beat_mask[k][b]) ref_mem[word_of(addr, k)][b*8 +: 8] = beat_data[k][b*8 +: 8];
        end
      end
    end
    nr = atomic ? nb : 1;
    for (int r = 0; r < nr; r++) begin
      recv_beat(1'b1, d, opc, den, cor, rsz, rsrc);
      check("ack_opcode", opc, atomic ? 64'd1 : ((op == 3'd5) ? 64'd2 : 64'd0));
      check("ack_denied_corrupt", {den, cor}, atomic ? 64'd3 : 64'd0);
      check("ack_source", rsrc, src);
      check("ack_size", rsz, 64'(sz));
      if (atomic) check("denied_data_zero", d, 64'd0);
    end
    #1;
    check("d_idle_after_ack", host.d_valid, 64'd0);
    check("a_ready_after_ack", host.a_ready, 64'd1);
  endtask

  task automatic get_txn(input int sz, input logic [55:0] addr, input logic [3:0] src, input bit rand_ready);
    int          nb;
    logic [63:0] d;
    logic [2:0]  opc, rsz;
    logic        den, cor;
    logic [3:0]  rsrc;
    nb = n_beats(sz);
    send_beat(3'd4, 3'(sz), addr, src, 64'd0, 8'hFF, 1'b0);
    #1;
    check("get_valid_latency", host.d_valid, 64'd1);
    check("get_a_ready_low", host.a_ready, 64'd0);
    for (int k = 0; k < nb; k++) exp_q.push_back(ref_mem[word_of(addr, k)]);
    for (int k = 0; k < nb; k++) begin
      recv_beat(rand_ready, d, opc, den, cor, rsz, rsrc);
      check("get_data", d, exp_q.pop_front());
      check("get_opcode", opc, 64'd1);
      check("get_denied_corrupt", {den, cor}, 64'd0);
      check("get_source", rsrc, src);
      check("get_size", rsz, 64'(sz));
    end
    #1;
    check("d_idle_after_get", host.d_valid, 64'd0);
    check("a_ready_after_get", host.a_ready, 64'd1);
  endtask

  task automatic fill_beats(input bit full_mask, input bit allow_corrupt);
    for (int k = 0; k < 16; k++) begin
      beat_data[k]    = {$urandom, $urandom};
      beat_mask[k]    = full_mask ? 8'hFF : 8'($urandom_range(0, 255));
      beat_corrupt[k] = allow_corrupt ? ($urandom_range(0, 9) == 0) : 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [2:0]  opc, rsz;
    logic        den, cor;
    logic [3:0]  rsrc;
    logic [55:0] a;
    int          sz, idx, kind;

    host.a_valid = 1'b0; host.a_opcode = '0; host.a_param = '0; host.a_size = '0;
    host.a_source = '0; host.a_address = '0; host.a_mask = '0; host.a_corrupt = 1'b0;
    host.a_data = '0; host.d_ready = 1'b0;

    // Reset behaviour
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_a_ready", host.a_ready, 64'd0);
    check("rst_d_valid", host.d_valid, 64'd0);
    check("rst_d_size", host.d_size, 64'd0);
    check("rst_d_source", host.d_source, 64'd0);
    check("rst_d_sink", host.d_sink, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_a_ready", host.a_ready, 64'd1);
    check("post_rst_d_valid", host.d_valid, 64'd0);

    // Give every word a known value
    for (int w = 0; w < DEPTH / 8; w++) begin
      fill_beats(1'b1, 1'b0);
      put_txn(3'd0, 6, 56'(w) << 6, 4'($urandom_range(0, 15)));
    end

    // PutFull then Get at 0x40
    beat_data[0] = 64'h1122334455667788; beat_mask[0] = 8'hFF; beat_corrupt[0] = 1'b0;
    put_txn(3'd0, 3, 56'h40, 4'd3);
    get_txn(3, 56'h40, 4'd5, 1'b0);

    // PutPartial low four lanes
    beat_data[0] = 64'hAAAAAAAABBBBBBBB; beat_mask[0] = 8'h0F; beat_corrupt[0] = 1'b0;
    put_txn(3'd1, 3, 56'h40, 4'd7);
    get_txn(3, 56'h40, 4'd1, 1'b0);

    // 8-beat burst with data k, then read it back with random backpressure
    for (int k = 0; k < 8; k++) begin
      beat_data[k] = 64'(k); beat_mask[k] = 8'hFF; beat_corrupt[k] = 1'b0;
    end
    put_txn(3'd0, 6, 56'h100, 4'd2);
    get_txn(6, 56'h100, 4'd4, 1'b1);

    // Arithmetic (1 beat) and Logical (2 beats) are denied and leave memory alone
    fill_beats(1'b1, 1'b0);
    put_txn(3'd2, 3, 56'h40, 4'd6);
    get_txn(3, 56'h40, 4'd6, 1'b0);
    fill_beats(1'b1, 1'b0);
    put_txn(3'd3, 4, 56'h100, 4'd8);
    get_txn(4, 56'h100, 4'd8, 1'b1);

    // Intent, then an aliased Get one memory-size above 0x40
    put_txn(3'd5, 6, 56'h40, 4'd9);
    get_txn(3, 56'h40 + 56'(DEPTH * 8), 4'd10, 1'b0);

    // Reset while streaming beat 3 of an 8-beat Get
    send_beat(3'd4, 3'd6, 56'h100, 4'd11, 64'd0, 8'hFF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      recv_beat(1'b0, d, opc, den, cor, rsz, rsrc);
      check("pre_rst_data", d, ref_mem[word_of(56'h100, k)]);
    end
    #1;
    check("read_beat3_valid", host.d_valid, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_d_valid", host.d_valid, 64'd0);
    check("mid_rst_a_ready", host.a_ready, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("after_rst_a_ready", host.a_ready, 64'd1);
    get_txn(6, 56'h100, 4'd12, 1'b1);

    // Randomized mix of Puts (some corrupt beats) and Gets with aliasing upper bits
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      sz   = (kind == 2) ? $urandom_range(0, 6) : $urandom_range(3, 6);
      idx  = $urandom_range(0, DEPTH - 1) & ~(n_beats(sz) - 1);
      a    = 56'(idx) << 3;
      if (sz < 3) a = a + 56'($urandom_range(0, 7) & ~((1 << sz) - 1));
      a    = a | (56'($urandom_range(0, 3)) << 12);
      if (kind == 2) begin
        get_txn(sz, a, 4'($urandom_range(0, 15)), 1'b1);
      end else begin
        fill_beats(kind == 0, 1'b1);
        put_txn(3'(kind), sz, a, 4'($urandom_range(0, 15)));
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
